// File: rtl/dlsc_i2c_apb_sequencer.sv
// APB master that drives an OpenCores I2C core: programs prescaler/enable after reset,
// then turns byte-level I2C commands into TXR/CR writes plus SR polling and returns status.
module dlsc_i2c_apb_sequencer #(
  parameter int unsigned     ADDR      = 32,
  parameter logic [ADDR-1:0] BASE      = '0,
  parameter logic [15:0]     PRESCALE  = 16'd99,
  parameter int unsigned     POLL_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_read,
  input  logic            cmd_start,
  input  logic            cmd_stop,
  input  logic            cmd_nack,
  input  logic [7:0]      cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_data,
  output logic            rsp_nack,
  output logic            rsp_al,
  output logic            init_done,
  output logic [ADDR-1:0] apb_addr,
  output logic            apb_sel,
  output logic            apb_enable,
  output logic            apb_write,
  output logic [31:0]     apb_wdata,
  output logic [3:0]      apb_strb,
  input  logic            apb_ready,
  input  logic [31:0]     apb_rdata
);

  localparam int unsigned     CW        = (POLL_WAIT > 1) ? $clog2(POLL_WAIT) : 1;
  localparam logic [CW-1:0]   WAIT_LOAD = CW'((POLL_WAIT > 0) ? POLL_WAIT - 1 : 0);

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXRXR  = 3'd3;
  localparam logic [2:0] REG_CRSR   = 3'd4;

  typedef enum logic [3:0] {
    S_INIT_PRL,
    S_INIT_PRH,
    S_INIT_CTR,
    S_IDLE,
    S_WR_TXR,
    S_WR_CR,
    S_POLL,
    S_WAIT,
    S_RD_RXR,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       wr;
    logic [7:0] data;
  } beat_t;

  // Register index, direction and byte for the APB transfer a given state performs.
  function automatic beat_t beat_for(input state_t s, input logic rd, input logic sta,
                                     input logic sto, input logic nack, input logic [7:0] data);
    beat_t b;
    b = '0;
    case (s)
      S_INIT_PRL: b = '{idx: REG_PRERLO, wr: 1'b1, data: PRESCALE[7:0]};
      S_INIT_PRH: b = '{idx: REG_PRERHI, wr: 1'b1, data: PRESCALE[15:8]};
      S_INIT_CTR: b = '{idx: REG_CTR,    wr: 1'b1, data: 8'h80};
      S_WR_TXR:   b = '{idx: REG_TXRXR,  wr: 1'b1, data: data};
      S_WR_CR:    b = '{idx: REG_CRSR,   wr: 1'b1,
                        data: rd ? {sta, sto, 1'b1, 1'b0, nack, 3'b000}
                                 : {sta, sto, 1'b0, 1'b1, 1'b0, 3'b000}};
      S_POLL:     b = '{idx: REG_CRSR,   wr: 1'b0, data: 8'h00};
      S_RD_RXR:   b = '{idx: REG_TXRXR,  wr: 1'b0, data: 8'h00};
      default:    b = '0;
    endcase
    return b;
  endfunction

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          en_q, en_d;
  logic          write_q, write_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          sta_q, sta_d;
  logic          sto_q, sto_d;
  logic          nack_q, nack_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_nack_q, rsp_nack_d;
  logic          rsp_al_q, rsp_al_d;
  logic          init_done_q, init_done_d;

  logic          eff_rd, eff_sta, eff_sto, eff_nack;
  logic [7:0]    eff_data;
  logic          start;
  beat_t         beat;

  // The first command beat is set up in the accept cycle, before the latches update.
  always_comb begin
    eff_rd   = (state_q == S_IDLE) ? cmd_read  : rd_q;
    eff_sta  = (state_q == S_IDLE) ? cmd_start : sta_q;
    eff_sto  = (state_q == S_IDLE) ? cmd_stop  : sto_q;
    eff_nack = (state_q == S_IDLE) ? cmd_nack  : nack_q;
    eff_data = (state_q == S_IDLE) ? cmd_data  : data_q;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    write_d     = write_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    sta_d       = sta_q;
    sto_d       = sto_q;
    nack_d      = nack_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    rsp_al_d    = rsp_al_q;
    init_done_d = init_done_q;
    start       = 1'b0;
    beat        = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rd_d       = cmd_read;
          sta_d      = cmd_start;
          sto_d      = cmd_stop;
          nack_d     = cmd_nack;
          data_d     = cmd_data;
          rsp_data_d = 8'h00;
          rsp_nack_d = 1'b0;
          rsp_al_d   = 1'b0;
          state_d    = cmd_read ? S_WR_CR : S_WR_TXR;
          start      = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_POLL;
          start   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        // Every remaining state owns one APB transfer: SETUP, then ACCESS until ready.
        if (!sel_q) begin
          start = 1'b1;
        end else if (!en_q) begin
          en_d = 1'b1;
        end else if (apb_ready) begin
          sel_d = 1'b0;
          en_d  = 1'b0;
          case (state_q)
            S_INIT_PRL: begin state_d = S_INIT_PRH; start = 1'b1; end
            S_INIT_PRH: begin state_d = S_INIT_CTR; start = 1'b1; end
            S_INIT_CTR: begin state_d = S_IDLE; init_done_d = 1'b1; end
            S_WR_TXR:   begin state_d = S_WR_CR; start = 1'b1; end
            S_WR_CR:    begin state_d = S_POLL;  start = 1'b1; end
            S_POLL: begin
              if (apb_rdata[1]) begin
                if (POLL_WAIT == 0) begin
                  state_d = S_POLL;
                  start   = 1'b1;
                end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
                end
              end else begin
                rsp_nack_d = ~rd_q & apb_rdata[7];
                rsp_al_d   = apb_rdata[5];
                if (rd_q) begin
                  state_d = S_RD_RXR;
                  start   = 1'b1;
                end else begin
                  state_d = S_RESP;
                end
              end
            end
            S_RD_RXR: begin
              rsp_data_d = apb_rdata[7:0];
              state_d    = S_RESP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    if (start) begin
      beat    = beat_for(state_d, eff_rd, eff_sta, eff_sto, eff_nack, eff_data);
      sel_d   = 1'b1;
      en_d    = 1'b0;
      idx_d   = beat.idx;
      write_d = beat.wr;
      byte_d  = beat.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT_PRL;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      byte_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      sta_q       <= 1'b0;
      sto_q       <= 1'b0;
      nack_q      <= 1'b0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
      rsp_al_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      sta_q       <= sta_d;
      sto_q       <= sto_d;
      nack_q      <= nack_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_al_q    <= rsp_al_d;
      init_done_q <= init_done_d;
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^apb_rdata[31:8];

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_nack   = rsp_nack_q;
  assign rsp_al     = rsp_al_q;
  assign init_done  = init_done_q;
  assign apb_addr   = BASE + ADDR'({idx_q, 2'b00});
  assign apb_sel    = sel_q;
  assign apb_enable = en_q;
  assign apb_write  = write_q;
  assign apb_wdata  = {24'd0, byte_q};
  assign apb_strb   = write_q ? 4'b0001 : 4'b0000;

endmodule

// File: tb/tb_dlsc_i2c_apb_sequencer.sv
// Scoreboard bench: stimulus queues expected APB beats and responses, negedge monitors check them.
module tb_dlsc_i2c_apb_sequencer;

  localparam int unsigned PW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_read = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_nack = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_nack, rsp_al, init_done;
  logic [31:0] apb_addr;
  logic        apb_sel, apb_enable, apb_write;
  logic [31:0] apb_wdata;
  logic [3:0]  apb_strb;
  logic        apb_ready = 1'b0;
  logic [31:0] apb_rdata = 32'hFFFF_FFFF;

  dlsc_i2c_apb_sequencer #(
    .ADDR(32), .BASE(32'h0), .PRESCALE(16'd99), .POLL_WAIT(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_nack(cmd_nack), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nack(rsp_nack), .rsp_al(rsp_al), .init_done(init_done),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_wdata(apb_wdata), .apb_strb(apb_strb), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [31:0] addr; logic wr; logic [7:0] data; } apb_t;
  typedef struct { logic [7:0] data; logic nack; logic al; } rsp_t;

  apb_t       exp_apb[$];
  rsp_t       exp_rsp[$];
  logic [7:0] sr_q[$];
  int         sr_cyc_q[$];
  logic [7:0] sr_default = 8'h00;
  logic [7:0] rxr_val = 8'h00;
  int         ws = 0;
  int         wcnt = 0;
  int         ctr_cyc = -1;
  int         checks = 0;
  int         errors = 0;

  apb_t       mon_e;
  rsp_t       mon_r;
  logic [7:0] mon_b;
  logic       hs_prev = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic void push_apb(input logic [31:0] a, input logic w, input logic [7:0] d);
    apb_t e;
    e.addr = a; e.wr = w; e.data = d;
    exp_apb.push_back(e);
  endfunction

  function automatic void push_rsp(input logic [7:0] d, input logic n, input logic a);
    rsp_t r;
    r.data = d; r.nack = n; r.al = a;
    exp_rsp.push_back(r);
  endfunction

  function automatic void push_init();
    push_apb(32'h00, 1'b1, 8'h63);
    push_apb(32'h04, 1'b1, 8'h00);
    push_apb(32'h08, 1'b1, 8'h80);
  endfunction

  // APB slave with configurable wait states plus transfer checker.
  always @(negedge clk) begin
    if (rst) begin
      apb_ready = 1'b0;
      apb_rdata = 32'hFFFF_FFFF;
      wcnt = 0;
    end else if (apb_sel) begin
      if (exp_apb.size() == 0) begin
        checks++; errors++;
        $display("FAIL apb_unexpected: got addr %0h write %0b, no transfer expected", apb_addr, apb_write);
      end else begin
        mon_e = exp_apb[0];
        chk("apb_addr", 64'(apb_addr), 64'(mon_e.addr));
        if (mon_e.wr)
          chk("apb_write_beat", 64'({apb_write, apb_strb, apb_wdata}), 64'({1'b1, 4'b0001, 24'd0, mon_e.data}));
        else
          chk("apb_read_beat", 64'({apb_write, apb_strb}), 64'({1'b0, 4'b0000}));
      end
      if (apb_enable) begin
        if (wcnt >= ws) begin
          apb_ready = 1'b1;
          mon_b = rxr_val;
          if (!apb_write && apb_addr[4:2] == 3'd4) begin
            if (sr_q.size() > 0) mon_b = sr_q.pop_front();
            else mon_b = sr_default;
            sr_cyc_q.push_back(cyc);
          end
          if (apb_write && apb_addr[4:2] == 3'd2) ctr_cyc = cyc;
          apb_rdata = {24'd0, mon_b};
          if (exp_apb.size() > 0) void'(exp_apb.pop_front());
        end else begin
          apb_ready = 1'b0;
          apb_rdata = 32'hFFFF_FFFF;
          wcnt++;
        end
      end else begin
        apb_ready = 1'b0;
        apb_rdata = 32'hFFFF_FFFF;
        wcnt = 0;
      end
    end else begin
      apb_ready = 1'b0;
      apb_rdata = 32'hFFFF_FFFF;
      wcnt = 0;
    end
  end

  // Response channel and cmd_ready monitor.
  always @(negedge clk) begin
    if (rst) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("idle_after_rsp", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        hs_prev = 1'b0;
      end
      if (!init_done) chk("cmd_ready_pre_init", 64'(cmd_ready), 64'(0));
      if (rsp_valid) begin
        chk("cmd_ready_during_rsp", 64'(cmd_ready), 64'(0));
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got data %0h nack %0b al %0b, no response expected",
                   rsp_data, rsp_nack, rsp_al);
        end else begin
          mon_r = exp_rsp[0];
          chk("rsp_fields", 64'({rsp_data, rsp_nack, rsp_al}), 64'({mon_r.data, mon_r.nack, mon_r.al}));
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            hs_prev = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_init();
    int dc;
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_done) begin dc = cyc; break; end
    end
    chk("init_done_seen", 64'(dc >= 0), 64'(1));
    if (dc >= 0) chk("init_done_timing", 64'(dc), 64'(ctr_cyc + 1));
    chk("init_writes_done", 64'(exp_apb.size()), 64'(0));
  endtask

  task automatic issue_cmd(input logic rd, input logic sta, input logic sto, input logic nk,
                           input logic [7:0] d, output int t);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = rd; cmd_start = sta; cmd_stop = sto; cmd_nack = nk; cmd_data = d;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t = cyc; break; end
    end
    chk("cmd_accepted", 64'(t >= 0), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 8'h00;
  endtask

  task automatic wait_rsp(input int hold, output int rc);
    rc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rc = cyc; break; end
    end
    chk("rsp_seen", 64'(rc >= 0), 64'(1));
    if (rc >= 0) begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rc, found;

    // Reset values and init sequence
    repeat (3) @(posedge clk); #1;
    chk("reset_ctl", 64'({apb_sel, apb_enable, apb_write, apb_strb, cmd_ready, rsp_valid,
                          init_done, rsp_nack, rsp_al, rsp_data}), 64'(0));
    chk("reset_addr_wdata", 64'({apb_addr, apb_wdata}), 64'(0));
    push_init();
    @(negedge clk); rst = 1'b0;
    wait_init();

    // Write A5 with START, two TIP=1 polls before completion
    sr_q = '{8'h02, 8'h02, 8'h00};
    sr_cyc_q.delete();
    push_apb(32'h0C, 1'b1, 8'hA5);
    push_apb(32'h10, 1'b1, 8'h90);
    repeat (3) push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, t);
    wait_rsp(0, rc);
    chk("sr_read_count", 64'(sr_cyc_q.size()), 64'(3));
    if (sr_cyc_q.size() == 3) begin
      chk("poll_gap1", 64'(sr_cyc_q[1] - sr_cyc_q[0]), 64'(PW + 2));
      chk("poll_gap2", 64'(sr_cyc_q[2] - sr_cyc_q[1]), 64'(PW + 2));
    end

    // Write with STOP, slave NACK; then arbitration lost
    sr_q = '{8'h80};
    push_apb(32'h0C, 1'b1, 8'h11);
    push_apb(32'h10, 1'b1, 8'h50);
    push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b1, 1'b0);
    issue_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, t);
    wait_rsp(0, rc);
    chk("write_latency", 64'(rc - t), 64'(7));

    sr_q = '{8'h20};
    push_apb(32'h0C, 1'b1, 8'h22);
    push_apb(32'h10, 1'b1, 8'h50);
    push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b0, 1'b1);
    issue_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, t);
    wait_rsp(0, rc);

    // Read with NACK+STOP; SR RxACK set must not leak into a read response
    sr_q = '{8'h80};
    rxr_val = 8'h3C;
    push_apb(32'h10, 1'b1, 8'h68);
    push_apb(32'h10, 1'b0, 8'h00);
    push_apb(32'h0C, 1'b0, 8'h00);
    push_rsp(8'h3C, 1'b0, 1'b0);
    issue_cmd(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, t);
    wait_rsp(0, rc);
    chk("read_latency", 64'(rc - t), 64'(7));

    // Slow slave and slow response consumer
    ws = 3;
    sr_q = '{8'h00};
    push_apb(32'h0C, 1'b1, 8'h5A);
    push_apb(32'h10, 1'b1, 8'h90);
    push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, t);
    wait_rsp(5, rc);

    sr_q = '{8'h00};
    rxr_val = 8'hC3;
    push_apb(32'h10, 1'b1, 8'hA0);
    push_apb(32'h10, 1'b0, 8'h00);
    push_apb(32'h0C, 1'b0, 8'h00);
    push_rsp(8'hC3, 1'b0, 1'b0);
    issue_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t);
    wait_rsp(5, rc);

    // Reset during a poll access
    sr_default = 8'h02;
    push_apb(32'h0C, 1'b1, 8'h77);
    push_apb(32'h10, 1'b1, 8'h90);
    push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, t);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (apb_sel && apb_enable && !apb_write && apb_addr[4:2] == 3'd4) begin found = 1; break; end
    end
    chk("poll_reached", 64'(found), 64'(1));
    #1 rst = 1'b1;
    exp_apb.delete();
    exp_rsp.delete();
    sr_q.delete();
    sr_default = 8'h00;
    ws = 0;
    #1;
    chk("reset_drops_apb", 64'({apb_sel, apb_enable, rsp_valid, cmd_ready, init_done}), 64'(0));
    repeat (3) @(posedge clk); #1;
    chk("reset_held_idle", 64'({apb_sel, rsp_valid}), 64'(0));
    push_init();
    @(negedge clk); rst = 1'b0;
    wait_init();

    sr_q = '{8'h00};
    push_apb(32'h0C, 1'b1, 8'h01);
    push_apb(32'h10, 1'b1, 8'hD0);
    push_apb(32'h10, 1'b0, 8'h00);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue_cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, t);
    wait_rsp(0, rc);

    repeat (4) @(negedge clk);
    chk("apb_queue_drained", 64'(exp_apb.size()), 64'(0));
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
